inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage for the 32-bit teaching CPU. It drives the word address of the 64-entry combinational instruction ROM and samples the returned instruction word. It presents a registered IF/ID pipeline register (PC, instruction, valid) to decode. It supports decode-side stalls and execute-side redirects (branch/jump).

## Interface
Parameters:
- AW, 6, ROM word-address width (64 words)
- IW, 32, instruction width
- CW, 16, width of the fetched-instruction counter

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high
- a  output  AW  ROM word address, driven combinationally from the PC register
- inst  input  IW  ROM read data for address a, combinational, valid in the same cycle
- stall  input  1  decode cannot accept; hold PC and IF/ID contents
- redirect  input  1  load PC from redirect_pc and kill the current IF/ID entry
- redirect_pc  input  AW  redirect target word address
- if_pc  output  AW  address of the instruction held in IF/ID
- if_inst  output  IW  instruction held in IF/ID
- if_valid  output  1  IF/ID entry is a real fetched instruction
- fetch_cnt  output  CW  count of instructions accepted into IF/ID, saturating

## Operation
- State machine: BOOT, RUN.
  - BOOT is entered on reset and lasts exactly one cycle after rst deasserts.
  - In BOOT: a=0, no IF/ID load, no PC increment. Next state is always RUN.
  - RUN persists until reset.
- PC register pc[AW-1:0], with a = pc at all times.
- Actions in RUN, evaluated each rising edge in priority order:
  - redirect=1:
    - pc <= redirect_pc; if_valid <= 0
    - if_pc and if_inst keep their values
    - fetch_cnt unchanged
    - Redirect wins over a simultaneous stall.
  - else stall=1:
    - pc, if_pc, if_inst, if_valid, fetch_cnt all hold.
  - else:
    - if_inst <= inst; if_pc <= pc; if_valid <= 1
    - pc <= pc+1, modulo 2^AW, so 63 wraps to 0
    - fetch_cnt <= fetch_cnt+1, saturating at 2^CW-1
- redirect and stall are ignored in BOOT.
- Instruction content is not interpreted. An all-zero word is a normal valid nop and is counted.
- Field layout delivered to decode (informative only):
  - op [31:26]
  - R-type: func [25:20], shamt [19:15], rd [14:10], rs [9:5], rt [4:0]
  - I-type: imm16 [25:10], rs [9:5], rt [4:0]

## Timing
- Reset values, applied immediately on rst rising, independent of clk:
  - pc=0, a=0, if_pc=0, if_inst=0, if_valid=0, fetch_cnt=0, state=BOOT
- Reset asserted mid-run discards the IF/ID entry and the PC immediately. Fetch restarts from address 0 after BOOT.
- Fetch latency: the ROM word at address N appears on if_inst/if_valid one edge after pc=N is presented with stall=0 and redirect=0.
- First valid: if rst deasserts before edge E0, then:
  - E0 is spent in BOOT.
  - At E1, address 0 is loaded: if_valid=1, if_pc=0.
  - At E2, address 1 is loaded, and so on.
- Throughput: one instruction per cycle when stall=0.
- Redirect penalty:
  - Redirect asserted in cycle k: after edge k, if_valid=0 and a=redirect_pc.
  - After edge k+1, the target instruction is valid, assuming no stall.
- Handshake: decode consumes IF/ID at an edge where if_valid=1 and stall=0. A held entry stays stable for the whole stall.
- Wrap-around: pc=63 with no stall loads inst[63] and sets pc=0 in the same edge.
- fetch_cnt saturation: at 2^CW-1 the counter holds while fetch proceeds normally.

## Test plan
- Reset/boot: assert rst, release, run 4 edges with a ROM model (word n = 0x1000_0000+n):
  - if_valid=0 after E0
  - after E1: if_pc=0, if_inst=0x1000_0000
  - after E3: if_pc=2, fetch_cnt=3
- Stall hold: after if_pc=2, hold stall=1 for 3 edges:
  - a=3, if_pc=2, if_inst=0x1000_0002, fetch_cnt=3 throughout
  - release: next edge gives if_pc=3
- Redirect priority: at pc=5, assert redirect=1 with redirect_pc=40 and stall=1 together:
  - next edge: if_valid=0, a=40
  - following edge (stall=0): if_pc=40, if_inst=0x1000_0028
- Wrap: redirect to 62, then free-run:
  - if_pc sequence 62, 63, 0, 1
  - a=0 immediately after the edge that loads 63
- Async reset mid-run: pulse rst between edges while if_valid=1, pc=20:
  - all outputs zero without a clock edge
  - BOOT cycle repeats, then if_pc=0
- Counter saturation (CW=4 override): free-run 20 fetches:
  - fetch_cnt reaches 15 and holds
  - if_pc continues incrementing

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: ROM address/data, decode-side control, and the IF/ID register view.
interface inst_fetch_if #(
  parameter int AW = 6,
  parameter int IW = 32,
  parameter int CW = 16
);
  logic [AW-1:0] a;
  logic [IW-1:0] inst;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] if_pc;
  logic [IW-1:0] if_inst;
  logic          if_valid;
  logic [CW-1:0] fetch_cnt;

  modport master (
    output a, if_pc, if_inst, if_valid, fetch_cnt,
    input  inst, stall, redirect, redirect_pc
  );
  modport slave (
    input  a, if_pc, if_inst, if_valid, fetch_cnt,
    output inst, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC drives the combinational ROM, result lands in the IF/ID register.
// One BOOT cycle after reset, then one fetch per unstalled cycle; redirect beats stall.
module inst_fetch #(
  parameter int AW = 6,
  parameter int IW = 32,
  parameter int CW = 16
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);
  typedef enum logic {BOOT, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] if_pc_q, if_pc_d;
  logic [IW-1:0] if_inst_q, if_inst_d;
  logic          if_valid_q, if_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    cnt_d      = cnt_q;
    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (bus.redirect) begin
      // Kill the IF/ID entry but leave its pc/inst fields as they were.
      pc_d       = bus.redirect_pc;
      if_valid_d = 1'b0;
    end else if (!bus.stall) begin
      if_inst_d  = bus.inst;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + AW'(1);
      cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.a         = pc_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.fetch_cnt = cnt_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: boot, stall, redirect priority, wrap, async reset,
// and counter saturation on a second CW=4 instance.
module tb_inst_fetch;
  logic clk;
  logic rst;
  logic rst_s;
  int   n_chk;
  int   n_err;

  inst_fetch_if #(.AW(6), .IW(32), .CW(16)) bus ();
  inst_fetch_if #(.AW(6), .IW(32), .CW(4))  bus4 ();

  inst_fetch #(.AW(6), .IW(32), .CW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );
  inst_fetch #(.AW(6), .IW(32), .CW(4)) dut4 (
    .clk(clk), .rst(rst_s), .bus(bus4.master)
  );

  // ROM model: word n = 0x1000_0000 + n
  assign bus.inst  = 32'h1000_0000 + 32'(bus.a);
  assign bus4.inst = 32'h1000_0000 + 32'(bus4.a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    rst_s = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus4.stall = 1'b0;
    bus4.redirect = 1'b0;
    bus4.redirect_pc = '0;
    #1;
    check("rst_a", 64'(bus.a), 0);
    check("rst_valid", 64'(bus.if_valid), 0);
    check("rst_inst", 64'(bus.if_inst), 0);
    check("rst_cnt", 64'(bus.fetch_cnt), 0);
    #11 rst = 1'b0;

    // boot
    step;
    check("boot_valid", 64'(bus.if_valid), 0);
    check("boot_a", 64'(bus.a), 0);
    step;
    check("e1_valid", 64'(bus.if_valid), 1);
    check("e1_pc", 64'(bus.if_pc), 0);
    check("e1_inst", 64'(bus.if_inst), 64'h1000_0000);
    step;
    check("e2_pc", 64'(bus.if_pc), 1);
    step;
    check("e3_pc", 64'(bus.if_pc), 2);
    check("e3_cnt", 64'(bus.fetch_cnt), 3);

    // stall hold
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      check("stall_a", 64'(bus.a), 3);
      check("stall_pc", 64'(bus.if_pc), 2);
      check("stall_inst", 64'(bus.if_inst), 64'h1000_0002);
      check("stall_cnt", 64'(bus.fetch_cnt), 3);
    end
    bus.stall = 1'b0;
    step;
    check("unstall_pc", 64'(bus.if_pc), 3);
    check("unstall_cnt", 64'(bus.fetch_cnt), 4);
    step;
    check("pc4", 64'(bus.if_pc), 4);
    check("a5", 64'(bus.a), 5);

    // redirect beats stall
    bus.redirect = 1'b1;
    bus.redirect_pc = 6'd40;
    bus.stall = 1'b1;
    step;
    check("redir_valid", 64'(bus.if_valid), 0);
    check("redir_a", 64'(bus.a), 40);
    check("redir_pc_kept", 64'(bus.if_pc), 4);
    check("redir_cnt", 64'(bus.fetch_cnt), 5);
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    step;
    check("tgt_pc", 64'(bus.if_pc), 40);
    check("tgt_inst", 64'(bus.if_inst), 64'h1000_0028);
    check("tgt_valid", 64'(bus.if_valid), 1);
    check("tgt_cnt", 64'(bus.fetch_cnt), 6);

    // wrap
    bus.redirect = 1'b1;
    bus.redirect_pc = 6'd62;
    step;
    check("w_valid", 64'(bus.if_valid), 0);
    bus.redirect = 1'b0;
    step;
    check("w_pc62", 64'(bus.if_pc), 62);
    step;
    check("w_pc63", 64'(bus.if_pc), 63);
    check("w_a0", 64'(bus.a), 0);
    check("w_inst63", 64'(bus.if_inst), 64'h1000_003f);
    step;
    check("w_pc0", 64'(bus.if_pc), 0);
    step;
    check("w_pc1", 64'(bus.if_pc), 1);
    check("w_cnt", 64'(bus.fetch_cnt), 10);

    // async reset mid-run at pc=20
    bus.redirect = 1'b1;
    bus.redirect_pc = 6'd19;
    step;
    bus.redirect = 1'b0;
    step;
    check("pre_a", 64'(bus.a), 20);
    check("pre_valid", 64'(bus.if_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("ar_a", 64'(bus.a), 0);
    check("ar_pc", 64'(bus.if_pc), 0);
    check("ar_inst", 64'(bus.if_inst), 0);
    check("ar_valid", 64'(bus.if_valid), 0);
    check("ar_cnt", 64'(bus.fetch_cnt), 0);
    #1 rst = 1'b0;
    step;
    check("ar_boot_valid", 64'(bus.if_valid), 0);
    check("ar_boot_a", 64'(bus.a), 0);
    step;
    check("ar_e1_pc", 64'(bus.if_pc), 0);
    check("ar_e1_valid", 64'(bus.if_valid), 1);
    check("ar_e1_cnt", 64'(bus.fetch_cnt), 1);

    // saturation on CW=4 instance
    #2 rst_s = 1'b0;
    step;
    check("sat_boot", 64'(bus4.if_valid), 0);
    for (int i = 1; i <= 20; i++) begin
      step;
      check("sat_cnt", 64'(bus4.fetch_cnt), (i > 15) ? 15 : i);
      check("sat_pc", 64'(bus4.if_pc), i - 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
